// File: rtl/mem_dump_unit.sv
// Post-run data-memory reader: streams a framed, checksummed image of data memory
// (header, word count, big-endian words, XOR checksum) over a byte valid/ready channel.
module mem_dump_unit #(
  parameter int WORDS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              dump_req,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR    = 4'd1,
    S_CNT_HI = 4'd2,
    S_CNT_LO = 4'd3,
    S_RD     = 4'd4,
    S_WAIT   = 4'd5,
    S_SEND   = 4'd6,
    S_CSUM   = 4'd7,
    S_DONE   = 4'd8
  } state_e;

  localparam logic [15:0]       WORDS_CNT = 16'(WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [7:0]        HDR_BYTE  = 8'hA5;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic                halt_prev_q, halt_prev_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                mem_ren_q, mem_ren_d;
  logic [ADDR_W-1:0]   mem_raddr_q, mem_raddr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                trigger_s;
  logic                accept_s;
  logic [7:0]          cur_byte_s;

  // Next-state logic; outputs are derived from the next state so they leave flops.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    halt_prev_d = halt;
    trigger_s   = dump_req | (halt & ~halt_prev_q);
    accept_s    = tx_valid_q & tx_ready;
    cur_byte_s  = word_byte(word_q, idx_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (trigger_s) begin
          state_d = S_HDR;
          csum_d  = 8'h00;
          addr_d  = '0;
          idx_d   = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_HDR:    state_d = accept_s ? S_CNT_HI : S_HDR;
      S_CNT_HI: state_d = accept_s ? S_CNT_LO : S_CNT_HI;
      S_CNT_LO: state_d = accept_s ? S_RD : S_CNT_LO;
      S_RD:     state_d = S_WAIT;
      S_WAIT: begin
        word_d  = mem_rdata;
        idx_d   = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (accept_s) begin
          csum_d = csum_q ^ cur_byte_s;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_CSUM;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_RD;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_CSUM:   state_d = accept_s ? S_DONE : S_CSUM;
      default:  state_d = S_IDLE;
    endcase

    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    case (state_d)
      S_HDR:    begin tx_valid_d = 1'b1; tx_data_d = HDR_BYTE;         end
      S_CNT_HI: begin tx_valid_d = 1'b1; tx_data_d = WORDS_CNT[15:8];  end
      S_CNT_LO: begin tx_valid_d = 1'b1; tx_data_d = WORDS_CNT[7:0];   end
      S_SEND:   begin tx_valid_d = 1'b1; tx_data_d = word_byte(word_d, idx_d); end
      S_CSUM:   begin tx_valid_d = 1'b1; tx_data_d = csum_d;           end
      default:  begin tx_valid_d = 1'b0; tx_data_d = 8'h00;            end
    endcase

    mem_ren_d   = (state_d == S_RD);
    mem_raddr_d = addr_d;
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      idx_q       <= 2'd0;
      word_q      <= 32'h0000_0000;
      csum_q      <= 8'h00;
      halt_prev_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      mem_ren_q   <= 1'b0;
      mem_raddr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      halt_prev_q <= halt_prev_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      mem_ren_q   <= mem_ren_d;
      mem_raddr_q <= mem_raddr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign mem_ren   = mem_ren_q;
  assign mem_raddr = mem_raddr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Bench for mem_dump_unit: two instances (2-word and 64-word images), a byte-stream
// monitor, and a frame model built directly from the memory image.
module tb_mem_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tx_ready;
  logic        halt_a, dump_a, ren_a, valid_a, busy_a, done_a;
  logic [0:0]  raddr_a;
  logic [31:0] rdata_a;
  logic [7:0]  data_a;
  logic        halt_b, dump_b, ren_b, valid_b, busy_b, done_b;
  logic [5:0]  raddr_b;
  logic [31:0] rdata_b;
  logic [7:0]  data_b;

  logic [31:0] mem_a [0:1];
  logic [31:0] mem_b [0:63];

  int checks = 0;
  int errors = 0;
  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  logic [7:0] exp_q[$];
  int         ren_cnt_a;
  int         ren_addr_a[$];
  logic       stall_a;
  logic [7:0] stall_data_a;
  int         rdy_mode;
  int         rc;

  mem_dump_unit #(.WORDS(2), .ADDR_W(1)) u_a (
    .clk(clk), .rst(rst), .halt(halt_a), .dump_req(dump_a), .mem_ren(ren_a),
    .mem_raddr(raddr_a), .mem_rdata(rdata_a), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(tx_ready), .busy(busy_a), .done(done_a));

  mem_dump_unit #(.WORDS(64), .ADDR_W(6)) u_b (
    .clk(clk), .rst(rst), .halt(halt_b), .dump_req(dump_b), .mem_ren(ren_b),
    .mem_raddr(raddr_b), .mem_rdata(rdata_b), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(tx_ready), .busy(busy_b), .done(done_b));

  // Synchronous-read memories: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (ren_a) rdata_a <= mem_a[raddr_a];
    if (ren_b) rdata_b <= mem_b[raddr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor, sampled mid-cycle: captures transfers, checks stall stability, logs reads.
  always @(negedge clk) begin
    if (rst) begin
      stall_a = 1'b0;
    end else begin
      if (valid_a) begin
        if (stall_a) chk("stall_hold", data_a, stall_data_a);
        if (tx_ready) begin
          cap_a.push_back(data_a);
          stall_a = 1'b0;
        end else begin
          stall_a      = 1'b1;
          stall_data_a = data_a;
        end
      end else begin
        if (stall_a) chk("stall_valid_drop", valid_a, 1'b1);
        stall_a = 1'b0;
      end
      if (ren_a) begin
        ren_cnt_a++;
        ren_addr_a.push_back(int'(raddr_a));
      end
      if (valid_b && tx_ready) cap_b.push_back(data_b);
    end
  end

  // Sink readiness: always ready, 1,0,0,1 pattern, or random.
  initial begin
    tx_ready = 1'b1;
    rc = 0;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    dump_a = 1'b1;
    tick();
    dump_a = 1'b0;
  endtask

  // Expected frame straight from the image: A5, count, big-endian words, XOR of data bytes.
  task automatic build_exp(input bit use_b);
    int n;
    logic [15:0] n16;
    logic [7:0]  cs;
    logic [31:0] w;
    n   = use_b ? 64 : 2;
    n16 = 16'(n);
    cs  = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(n16[15:8]);
    exp_q.push_back(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      w = use_b ? mem_b[i] : mem_a[i];
      for (int k = 3; k >= 0; k--) begin
        exp_q.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic cmp_frame(input string tag, input bit use_b);
    logic [7:0] got[$];
    int m;
    if (use_b) got = cap_b;
    else       got = cap_a;
    chk({tag, "_len"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic wait_done(input bit use_b, input int budget, output int cyc);
    cyc = 0;
    while (!(use_b ? done_b : done_a) && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("done_reached", use_b ? done_b : done_a, 1'b1);
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_valid"}, valid_a, 1'b0);
    chk({tag, "_busy"},  busy_a,  1'b0);
    chk({tag, "_done"},  done_a,  1'b0);
    chk({tag, "_ren"},   ren_a,   1'b0);
    chk({tag, "_raddr"}, raddr_a, 1'b0);
    chk({tag, "_data"},  data_a,  8'h00);
  endtask

  initial begin
    int cyc;
    int n;
    rst = 1'b1; halt_a = 1'b0; halt_b = 1'b0; dump_a = 1'b0; dump_b = 1'b0; rdy_mode = 0;
    for (int i = 0; i < 2; i++)  mem_a[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem_b[i] = 32'h0;
    repeat (3) tick();
    check_idle_a("reset");
    chk("reset_b_valid", valid_b, 1'b0);
    chk("reset_b_busy", busy_b, 1'b0);
    rst = 1'b0;
    tick();
    check_idle_a("post_reset");

    // Basic frame
    mem_a[0] = 32'h11223344; mem_a[1] = 32'hDEADBEEF;
    cap_a.delete();
    pulse_a();
    chk("start_valid", valid_a, 1'b1);
    chk("start_hdr", data_a, 8'hA5);
    chk("start_busy", busy_a, 1'b1);
    wait_done(1'b0, 100, cyc);
    chk("basic_done_latency", cyc, 16);
    build_exp(1'b0);
    cmp_frame("basic", 1'b0);
    chk("basic_csum", cap_a[11], 8'h66);
    chk("basic_busy_end", busy_a, 1'b0);

    // Backpressure 1,0,0,1
    rdy_mode = 1;
    cap_a.delete(); ren_cnt_a = 0; ren_addr_a.delete();
    pulse_a();
    wait_done(1'b0, 200, cyc);
    cmp_frame("bp", 1'b0);
    chk("bp_ren_count", ren_cnt_a, 2);
    chk("bp_ren_addr0", ren_addr_a[0], 0);
    chk("bp_ren_addr1", ren_addr_a[1], 1);

    // Random images with random readiness
    rdy_mode = 2;
    for (int r = 0; r < 3; r++) begin
      mem_a[0] = $urandom; mem_a[1] = $urandom;
      cap_a.delete();
      pulse_a();
      wait_done(1'b0, 400, cyc);
      build_exp(1'b0);
      cmp_frame($sformatf("rand%0d", r), 1'b0);
    end

    // Trigger while busy at word 1, byte 2
    rdy_mode = 0;
    tick(); tick();
    mem_a[0] = 32'h11223344; mem_a[1] = 32'hDEADBEEF;
    build_exp(1'b0);
    cap_a.delete();
    pulse_a();
    repeat (13) tick();
    chk("busytrig_pos", data_a, 8'hBE);
    dump_a = 1'b1;
    tick();
    dump_a = 1'b0;
    wait_done(1'b0, 100, cyc);
    cmp_frame("busytrig", 1'b0);
    n = cap_a.size();
    repeat (20) tick();
    chk("busytrig_no_refire", cap_a.size(), n);
    chk("busytrig_busy", busy_a, 1'b0);
    chk("busytrig_done", done_a, 1'b1);

    // Reset during SEND of word 0
    cap_a.delete();
    pulse_a();
    repeat (6) tick();
    chk("midrst_in_send", valid_a, 1'b1);
    rst = 1'b1;
    tick();
    check_idle_a("midrst");
    rst = 1'b0;
    n = cap_a.size();
    repeat (10) tick();
    chk("midrst_no_bytes", cap_a.size(), n);
    chk("midrst_idle_busy", busy_a, 1'b0);
    cap_a.delete();
    pulse_a();
    wait_done(1'b0, 100, cyc);
    cmp_frame("after_rst", 1'b0);

    // Re-dump from DONE with a changed word 0
    mem_a[0] = 32'h000000FF;
    build_exp(1'b0);
    cap_a.delete();
    pulse_a();
    chk("redump_done_drop", done_a, 1'b0);
    wait_done(1'b0, 100, cyc);
    cmp_frame("redump", 1'b0);

    // Halt edge on the 64-word instance, held high
    for (int i = 0; i < 64; i++) mem_b[i] = 32'(i);
    cap_b.delete();
    halt_b = 1'b1;
    tick();
    chk("halt_start_valid", valid_b, 1'b1);
    wait_done(1'b1, 1000, cyc);
    chk("halt_frame_cycles", cyc, 388);
    build_exp(1'b1);
    cmp_frame("halt", 1'b1);
    chk("halt_csum_zero", cap_b[259], 8'h00);
    n = cap_b.size();
    repeat (50) tick();
    chk("halt_held_no_refire", cap_b.size(), n);
    chk("halt_held_busy", busy_b, 1'b0);

    // Halt already high across reset release triggers a dump
    for (int i = 0; i < 64; i++) mem_b[i] = $urandom;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cap_b.delete();
    tick();
    chk("halt_rst_valid", valid_b, 1'b1);
    chk("halt_rst_hdr", data_b, 8'hA5);
    halt_b = 1'b0;
    wait_done(1'b1, 1000, cyc);
    build_exp(1'b1);
    cmp_frame("halt_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Post-run data-memory reader that streams the contents of the CPU's data memory out over a byte-wide valid/ready channel once the core halts, or on an explicit request. It is the read-back counterpart to the memory pre-load path: `data_mem` is filled before the run, and this block drains it afterwards for comparison against a golden image. It sits beside the CPU core, shares the data memory through a dedicated synchronous read port, and drives a byte sink such as a UART transmitter or bench monitor.

## Interface
- `WORDS`, default 64: number of 32-bit words dumped, starting at address 0. Legal range is 1..65535 and ≤ 2^`ADDR_W`.
- `ADDR_W`, default 6: word-address width of the memory read port.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `halt`  in  1  CPU halt flag; its rising edge triggers a dump.
- `dump_req`  in  1  single-cycle explicit dump trigger.
- `mem_ren`  out  1  memory read enable.
- `mem_raddr`  out  ADDR_W  memory word address.
- `mem_rdata`  in  32  read data, valid the cycle after `mem_ren`.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  the last frame has completed.

## Operation
- **Frame format** (bytes in order):
  - 0xA5 header.
  - `WORDS[15:8]`, then `WORDS[7:0]`.
  - Each word from address 0 to `WORDS-1`, big-endian (bits 31:24 first).
  - Checksum byte: XOR of all data bytes only, excluding header and count.
- **States:** IDLE, HDR, CNT_HI, CNT_LO, RD, WAIT, SEND, CSUM, DONE.
- **Trigger:** `dump_req`=1, or `halt`=1 with the registered previous `halt`=0. A trigger is sampled only in IDLE or DONE. It clears `done`, clears the checksum and address counter, and enters HDR.
- **HDR, CNT_HI, CNT_LO, CSUM:** present the byte with `tx_valid`=1. Advance on acceptance.
  - CNT_LO advances to RD.
  - CSUM advances to DONE.
- **RD:** `mem_ren`=1, `mem_raddr`=current address, `tx_valid`=0. Goes to WAIT.
- **WAIT:** latch `mem_rdata` into the word register. Goes to SEND with byte index 0.
- **SEND:** present byte[index]. On acceptance:
  - XOR the byte into the checksum.
  - If index<3, increment index.
  - Otherwise, if address=`WORDS-1`, go to CSUM.
  - Otherwise, increment address and go to RD.
- **DONE:** `done`=1, `busy`=0. Stays there until a trigger or `rst`.
- **Counters:**
  - The address counter is `ADDR_W` bits wide and never wraps, because the terminal compare happens before any increment.
  - The byte index is 2 bits.
  - The checksum register is 8 bits.
- **Triggers while busy** are ignored and not queued.
- **`halt` held high** does not retrigger. Only a new 0→1 edge does.
- **`rst` at any point**, including mid-frame:
  - IDLE next cycle.
  - `tx_valid`, `mem_ren`, `busy` and `done` all 0.
  - `mem_raddr`, `tx_data` and the checksum all 0.
  - The frame is aborted and no further bytes are produced.
  - Previous-`halt` register cleared to 0, so a `halt` that is already high at reset release triggers a dump.

## Timing
- **Output timing:**
  - All outputs are registered; their reset values are all 0.
  - `busy`=1 in every state except IDLE and DONE.
- **Start latency:** trigger sampled at edge N → `tx_valid`=1 with 0xA5 after edge N, i.e. in cycle N+1.
- **Handshake:**
  - A transfer occurs at an edge where `tx_valid` && `tx_ready`.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable and `tx_valid` stays asserted.
  - `tx_valid` never depends combinationally on `tx_ready`.
- **Memory read:** `mem_rdata` is sampled exactly one cycle after the `mem_ren` cycle. `mem_ren` is a single-cycle pulse per word.
- **Throughput with `tx_ready` held at 1:**
  - Header and count: 3 cycles.
  - Each word: 6 cycles (RD, WAIT, 4×SEND).
  - Checksum: 1 cycle.
  - Total frame = 4 + 6·`WORDS` cycles from the first `tx_valid` to DONE.
- **`done` timing:** asserted the cycle after the checksum byte is accepted.

## Test plan
- **Basic frame:** `WORDS`=2, mem[0]=0x11223344, mem[1]=0xDEADBEEF, `tx_ready`=1, pulse `dump_req`.
  - Stream must be A5 00 02 11 22 33 44 DE AD BE EF 66.
  - `done`=1 sixteen cycles after the first `tx_valid`.
- **Halt trigger:** `WORDS`=64, mem[i]=i, raise `halt` and hold it high.
  - Exactly one frame: A5 00 40, 256 data bytes, checksum 0x00.
  - No second frame while `halt` stays high.
- **Backpressure:** same image as the basic frame, `tx_ready` toggling 1,0,0,1 repeatedly.
  - Identical byte sequence.
  - `tx_data` constant through every stall cycle.
  - `mem_ren` pulses exactly twice, at addresses 0 and 1.
- **Busy trigger:** assert `dump_req` mid-frame, at word 1, byte 2.
  - The frame completes unchanged.
  - No second frame starts.
- **Reset mid-frame:** assert `rst` during SEND of word 0.
  - Next cycle: `tx_valid`=0, `busy`=0, `done`=0, and no further bytes.
  - A subsequent `dump_req` produces a full, correct frame starting at 0xA5.
- **Re-dump from DONE:** after a completed frame, change mem[0] to 0x000000FF and pulse `dump_req`.
  - `done` drops.
  - New frame carries 00 00 00 FF for word 0 and a correspondingly updated checksum.
